// File: rtl/serial_master_port.sv
// -----------------------------------------------------------------------------
// serial_master_port
//
// Bus-side master for a 1-bit serial system bus. A local device posts a
// parallel read or write request; this block serialises the address (and, for
// writes, the data) MSB-first on wr_bus under the slave's ready handshake, and
// for reads collects the returned word MSB-first from rd_bus under the slave's
// valid handshake. A slave may split a read and hold the master for as long as
// it likes; any other stall is bounded by TIMEOUT and ends in an aborted
// transfer (done + err).
//
// Parameters
//   ADDR_WIDTH  address bits serialised per transfer
//   DATA_WIDTH  data bits per write or read
//   TIMEOUT     wait cycles tolerated in REQ or WAIT_RD before abort (>= 2)
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   req           request strobe, only sampled while idle
//   mode          1 = write, 0 = read (captured with req)
//   addr          transfer address (captured with req)
//   wdata         write data (captured with req)
//   busy          high whenever a transfer is in progress
//   done          one-cycle end-of-transfer pulse
//   err           one-cycle pulse with done when the transfer was aborted
//   rdata         last successfully read word
//   wr_bus        serial address / write-data bit towards the slave
//   bus_mode      captured mode while busy, else 0
//   master_valid  a bit is presented on wr_bus
//   master_ready  master accepts a bit on rd_bus
//   rd_bus        serial read-data bit from the slave
//   slave_ready   slave takes the wr_bus bit at this edge
//   slave_valid   slave presents a valid rd_bus bit at this edge
//   split         slave has split the read; master waits without timing out
// -----------------------------------------------------------------------------
module serial_master_port #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wr_bus,
  output logic                  bus_mode,
  output logic                  master_valid,
  output logic                  master_ready,
  input  logic                  rd_bus,
  input  logic                  slave_ready,
  input  logic                  slave_valid,
  input  logic                  split
);

  localparam int FRAME_WIDTH = ADDR_WIDTH + DATA_WIDTH;
  localparam int BIT_CNT_W   = $clog2(FRAME_WIDTH) + 1;
  localparam int TMO_CNT_W   = $clog2(TIMEOUT) + 1;

  localparam logic [BIT_CNT_W-1:0] ADDR_BITS  = BIT_CNT_W'(ADDR_WIDTH);
  localparam logic [BIT_CNT_W-1:0] FRAME_BITS = BIT_CNT_W'(FRAME_WIDTH);
  localparam logic [BIT_CNT_W-1:0] DATA_BITS  = BIT_CNT_W'(DATA_WIDTH);
  localparam logic [TMO_CNT_W-1:0] TMO_LIMIT  = TMO_CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_WAIT_RD,
    S_RX,
    S_DONE
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q,    state_d;
  logic                   mode_q,     mode_d;
  logic                   err_q,      err_d;
  logic [FRAME_WIDTH-1:0] shift_q,    shift_d;     // {addr, wdata}, MSB out first
  logic [DATA_WIDTH-1:0]  rx_shift_q, rx_shift_d;  // read word being assembled
  logic [DATA_WIDTH-1:0]  rdata_q,    rdata_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
  logic [TMO_CNT_W-1:0]   tmo_cnt_q,  tmo_cnt_d;

  // ---------------------------------------------------------------------------
  // Helpers shared by several states
  // ---------------------------------------------------------------------------
  logic [BIT_CNT_W-1:0]   bit_cnt_inc;
  logic [TMO_CNT_W-1:0]   tmo_cnt_inc;
  logic [FRAME_WIDTH-1:0] shift_next;
  logic [DATA_WIDTH-1:0]  rx_word;

  assign bit_cnt_inc = bit_cnt_q + BIT_CNT_W'(1);
  assign tmo_cnt_inc = tmo_cnt_q + TMO_CNT_W'(1);
  assign shift_next  = shift_q << 1;
  // Incoming bit lands in the LSB, so the first bit received ends up as MSB.
  assign rx_word     = (rx_shift_q << 1) | DATA_WIDTH'(rd_bus);

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so they never glitch on inputs
  // (wr_bus additionally follows the shift register MSB).
  // ---------------------------------------------------------------------------
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign err          = err_q;
  assign master_valid = (state_q == S_REQ) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign master_ready = (state_q == S_WAIT_RD) || (state_q == S_RX);
  assign wr_bus       = master_valid & shift_q[FRAME_WIDTH-1];
  assign bus_mode     = busy & mode_q;
  assign rdata        = rdata_q;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case; a path that
    // leaves one unassigned would otherwise infer a latch.
    state_d    = state_q;
    mode_d     = mode_q;
    shift_d    = shift_q;
    rx_shift_d = rx_shift_q;
    rdata_d    = rdata_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    // err is only ever set on the edge that enters DONE, which makes it a
    // one-cycle pulse aligned with done.
    err_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          mode_d    = mode;
          shift_d   = {addr, wdata};
          bit_cnt_d = '0;
          tmo_cnt_d = '0;
          state_d   = S_REQ;
        end
      end

      // First address bit: waiting for the slave to pick up the request.
      S_REQ: begin
        if (slave_ready) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_inc;
          state_d   = S_ADDR;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
          if (tmo_cnt_inc == TMO_LIMIT) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end

      // Once the slave has started taking bits it must keep taking them;
      // a dropped ready mid-frame is treated as a broken transfer.
      S_ADDR: begin
        if (!slave_ready) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == ADDR_BITS) begin
            if (mode_q) begin
              state_d = S_DATA;
            end else begin
              bit_cnt_d = '0;
              tmo_cnt_d = '0;
              state_d   = S_WAIT_RD;
            end
          end
        end
      end

      S_DATA: begin
        if (!slave_ready) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_inc;
          if (bit_cnt_inc == FRAME_BITS) begin
            state_d = S_DONE;
          end
        end
      end

      // Waiting for the first read bit. A valid bit wins over split; split
      // freezes the timeout so a split read can wait indefinitely.
      S_WAIT_RD: begin
        if (slave_valid) begin
          rx_shift_d = rx_word;
          bit_cnt_d  = bit_cnt_inc;
          if (bit_cnt_inc == DATA_BITS) begin
            rdata_d = rx_word;
            state_d = S_DONE;
          end else begin
            state_d = S_RX;
          end
        end else if (!split) begin
          tmo_cnt_d = tmo_cnt_inc;
          if (tmo_cnt_inc == TMO_LIMIT) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end

      // Gaps in slave_valid simply stall; there is no timeout once data flows.
      S_RX: begin
        if (slave_valid) begin
          rx_shift_d = rx_word;
          bit_cnt_d  = bit_cnt_inc;
          if (bit_cnt_inc == DATA_BITS) begin
            rdata_d = rx_word;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of the others, independent of statement order.
    if (rst) begin
      // NOTE: the shift registers are data-path only but are cleared as well;
      // they are small, and a known value keeps wr_bus/rdata deterministic.
      state_q    <= S_IDLE;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      shift_q    <= '0;
      rx_shift_q <= '0;
      rdata_q    <= '0;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      shift_q    <= shift_d;
      rx_shift_q <= rx_shift_d;
      rdata_q    <= rdata_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

endmodule

// File: tb/tb_serial_master_port.sv
// -----------------------------------------------------------------------------
// tb_serial_master_port
//
// Self-checking bench for serial_master_port. A reactive slave drives the
// handshakes according to a per-transfer scenario (initial ready delay, ready
// drop, split length, read wait, RX gap). The expected outcome of each
// transfer -- bit stream, err flag, busy duration, rdata -- is computed from
// the scenario with plain arithmetic, independently of the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_serial_master_port;

  localparam int AW     = 16;
  localparam int DW     = 8;
  localparam int TMO    = 64;
  localparam int FW     = AW + DW;
  localparam int BUDGET = 1000;

  logic          clk;
  logic          rst;
  logic          req;
  logic          mode;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic [DW-1:0] rdata;
  logic          wr_bus;
  logic          bus_mode;
  logic          master_valid;
  logic          master_ready;
  logic          rd_bus;
  logic          slave_ready;
  logic          slave_valid;
  logic          split;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model_rdata;

  // One transfer plus the slave behaviour to apply to it.
  typedef struct packed {
    bit            mode;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            rdy_delay;   // REQ cycles with slave_ready=0 before taking bit 1
    int            drop_after;  // drop slave_ready once this many bits taken (-1: never)
    int            split_cyc;   // WAIT_RD cycles with split=1
    int            wait_cyc;    // further WAIT_RD cycles with nothing asserted
    int            gap_at;      // RX gap before this bit index (-1: none)
    int            gap_len;     // RX gap length
    logic [DW-1:0] rbyte;       // word the slave returns
  } xfer_t;

  serial_master_port #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .TIMEOUT    (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .mode         (mode),
    .addr         (addr),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rdata        (rdata),
    .wr_bus       (wr_bus),
    .bus_mode     (bus_mode),
    .master_valid (master_valid),
    .master_ready (master_ready),
    .rd_bus       (rd_bus),
    .slave_ready  (slave_ready),
    .slave_valid  (slave_valid),
    .split        (split)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] out_vec();
    return {busy, done, err, master_valid, master_ready, wr_bus, bus_mode};
  endfunction

  function automatic xfer_t mk(input bit m, input logic [AW-1:0] a,
                               input logic [DW-1:0] w, input logic [DW-1:0] rb);
    xfer_t x;
    x.mode       = m;
    x.addr       = a;
    x.wdata      = w;
    x.rdy_delay  = 0;
    x.drop_after = -1;
    x.split_cyc  = 0;
    x.wait_cyc   = 0;
    x.gap_at     = -1;
    x.gap_len    = 0;
    x.rbyte      = rb;
    return x;
  endfunction

  task automatic reset_dut();
    rst         = 1'b1;
    req         = 1'b0;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    split       = 1'b0;
    repeat (3) @(negedge clk);
    rst         = 1'b0;
    model_rdata = '0;
  endtask

  // Runs one transfer. Entered and left at a negedge with the DUT idle.
  task automatic run_xfer(input xfer_t x, input string name);
    int            frame_bits, exp_bits, exp_cyc;
    bit            exp_err, seen_done;
    int            cyc, bits, stall, rd_wait, rx_bits, gap_cnt, viol;
    logic [FW-1:0] frame, exp_stream, got;

    // Expected outcome from the scenario.
    frame_bits = x.mode ? FW : AW;
    frame      = {x.addr, x.wdata};
    exp_err    = 1'b0;
    exp_bits   = frame_bits;
    if (x.rdy_delay >= TMO) begin
      exp_err  = 1'b1;
      exp_bits = 0;
      exp_cyc  = TMO + 1;
    end else if (x.drop_after >= 0) begin
      exp_err  = 1'b1;
      exp_bits = x.drop_after;
      exp_cyc  = x.rdy_delay + x.drop_after + 2;
    end else if (!x.mode && x.wait_cyc >= TMO) begin
      exp_err  = 1'b1;
      exp_cyc  = x.rdy_delay + AW + x.split_cyc + TMO + 1;
    end else if (x.mode) begin
      exp_cyc  = x.rdy_delay + FW + 1;
    end else begin
      exp_cyc  = x.rdy_delay + AW + x.split_cyc + x.wait_cyc
               + ((x.gap_at > 0) ? x.gap_len : 0) + DW + 1;
    end
    exp_stream = frame >> (FW - exp_bits);
    if (!exp_err && !x.mode) model_rdata = x.rbyte;

    // Launch.
    req         = 1'b1;
    mode        = x.mode;
    addr        = x.addr;
    wdata       = x.wdata;
    slave_ready = 1'b0;
    slave_valid = 1'b0;
    split       = 1'b0;
    @(negedge clk);

    seen_done = 1'b0;
    cyc = 0; bits = 0; stall = 0; rd_wait = 0; rx_bits = 0; gap_cnt = 0; viol = 0;
    got = '0;
    while (!seen_done && cyc < BUDGET) begin
      cyc++;
      if (!busy) viol++;
      if (bus_mode !== x.mode) viol++;
      if (done) begin
        seen_done = 1'b1;
        if (master_valid || master_ready) viol++;
      end else begin
        // Phase is known from the bits already taken, not from the DUT.
        if (bits < frame_bits) begin
          if (!(master_valid && !master_ready)) viol++;
        end else begin
          if (!(!master_valid && master_ready)) viol++;
        end
        if (!master_valid && wr_bus) viol++;
        if (err) viol++;

        // Slave behaviour for the coming edge.
        if (master_valid) begin
          split       = 1'b0;
          slave_valid = 1'b0;
          rd_bus      = 1'($urandom);
          if (bits == 0 && stall < x.rdy_delay) begin
            slave_ready = 1'b0;
            stall++;
          end else if (bits == x.drop_after) begin
            slave_ready = 1'b0;
          end else begin
            slave_ready = 1'b1;
            got         = {got[FW-2:0], wr_bus};
            bits++;
          end
        end else if (master_ready) begin
          slave_ready = 1'($urandom);
          if (rd_wait < x.split_cyc) begin
            split = 1'b1; slave_valid = 1'b0; rd_bus = 1'($urandom);
            rd_wait++;
          end else if (rd_wait < x.split_cyc + x.wait_cyc) begin
            split = 1'b0; slave_valid = 1'b0; rd_bus = 1'($urandom);
            rd_wait++;
          end else if (rx_bits == x.gap_at && gap_cnt < x.gap_len) begin
            split = 1'b0; slave_valid = 1'b0; rd_bus = 1'($urandom);
            gap_cnt++;
          end else if (rx_bits < DW) begin
            split = 1'b0; slave_valid = 1'b1;
            rd_bus = x.rbyte[DW-1-rx_bits];
            rx_bits++;
          end else begin
            split = 1'b0; slave_valid = 1'b0;
          end
        end else begin
          slave_ready = 1'b1;
          slave_valid = 1'b0;
          split       = 1'b0;
        end
        @(negedge clk);
        // Request-side noise while busy must be ignored.
        req   = 1'($urandom);
        mode  = 1'($urandom);
        addr  = AW'($urandom);
        wdata = DW'($urandom);
      end
    end

    check({name, ":done_seen"}, 32'(seen_done), 32'd1);
    if (!seen_done) begin
      reset_dut();
      return;
    end
    check({name, ":err"},     32'(err),        32'(exp_err));
    check({name, ":nbits"},   32'(bits),       32'(exp_bits));
    check({name, ":stream"},  32'(got),        32'(exp_stream));
    check({name, ":busy_cyc"}, 32'(cyc),       32'(exp_cyc));
    check({name, ":invar"},   32'(viol),       32'd0);
    check({name, ":rdata"},   32'(rdata),      32'(model_rdata));

    // Hold req high through DONE: it must still return to IDLE for a cycle.
    req         = 1'b1;
    slave_valid = 1'b0;
    split       = 1'b0;
    @(negedge clk);
    check({name, ":idle"},    32'(out_vec()),  32'd0);
    req = 1'b0;
  endtask

  initial begin
    xfer_t x;
    int    viol;
    int    r;

    req = 1'b0; mode = 1'b0; addr = '0; wdata = '0;
    rd_bus = 1'b0; slave_ready = 1'b0; slave_valid = 1'b0; split = 1'b0;
    rst = 1'b1;
    model_rdata = '0;
    repeat (3) @(negedge clk);
    check("reset:outs",  32'(out_vec()), 32'd0);
    check("reset:rdata", 32'(rdata),     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait write.
    x = mk(1'b1, 16'h0005, 8'hA5, 8'h00);
    run_xfer(x, "wr_0005");

    // Read, slave answers 4 cycles after the address, with a 3-cycle RX gap.
    x = mk(1'b0, 16'h0003, 8'h00, 8'h3C);
    x.wait_cyc = 4; x.gap_at = 4; x.gap_len = 3;
    run_xfer(x, "rd_0003");

    // Long split: no timeout.
    x = mk(1'b0, 16'hBEEF, 8'h00, 8'hF0);
    x.split_cyc = 200;
    run_xfer(x, "rd_split");

    // Slave never ready: REQ timeout, rdata keeps 0xF0.
    x = mk(1'b0, 16'h1111, 8'h00, 8'h77);
    x.rdy_delay = TMO + 3;
    run_xfer(x, "rd_req_tmo");

    // One cycle short of the limit: no abort.
    x = mk(1'b1, 16'h8001, 8'h3C, 8'h00);
    x.rdy_delay = TMO - 1;
    run_xfer(x, "wr_req_edge");

    // Ready dropped after 7 address bits, then a clean write.
    x = mk(1'b1, 16'hFFFF, 8'hFF, 8'h00);
    x.drop_after = 7;
    run_xfer(x, "wr_drop7");
    x = mk(1'b1, 16'h0001, 8'h11, 8'h00);
    run_xfer(x, "wr_0001");

    // Read wait timeout boundary.
    x = mk(1'b0, 16'h4242, 8'h00, 8'h81);
    x.wait_cyc = TMO - 1;
    run_xfer(x, "rd_wait_edge");
    x = mk(1'b0, 16'h2424, 8'h00, 8'h18);
    x.split_cyc = 10; x.wait_cyc = TMO;
    run_xfer(x, "rd_wait_tmo");

    // Reset in the middle of the data phase of a write.
    req = 1'b1; mode = 1'b1; addr = 16'h1234; wdata = 8'h5A;
    slave_ready = 1'b1; slave_valid = 1'b0; split = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      req = 1'(i % 2);
    end
    check("rst_mid:in_data", 32'({busy, master_valid, master_ready}), 32'b110);
    rst = 1'b1;
    req = 1'b0;
    @(negedge clk);
    check("rst_mid:outs",  32'(out_vec()), 32'd0);
    check("rst_mid:rdata", 32'(rdata),     32'd0);
    rst = 1'b0;
    model_rdata = '0;
    viol = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy || done || err) viol++;
    end
    check("rst_mid:quiet", 32'(viol), 32'd0);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      x = mk(1'($urandom), AW'($urandom), DW'($urandom), DW'($urandom));
      r = int'($urandom_range(0, 99));
      if (r < 8)       x.rdy_delay = TMO + int'($urandom_range(0, 3));
      else if (r < 35) x.rdy_delay = int'($urandom_range(1, TMO - 1));
      r = int'($urandom_range(0, 99));
      if (r < 15) x.drop_after = int'($urandom_range(1, (x.mode ? FW : AW) - 1));
      r = int'($urandom_range(0, 99));
      if (r < 20) x.split_cyc = int'($urandom_range(1, 150));
      r = int'($urandom_range(0, 99));
      if (r < 10)      x.wait_cyc = TMO + int'($urandom_range(0, 2));
      else if (r < 20) x.wait_cyc = TMO - 1;
      else             x.wait_cyc = int'($urandom_range(0, 8));
      r = int'($urandom_range(0, 99));
      if (r < 30) begin
        x.gap_at  = int'($urandom_range(1, DW - 1));
        x.gap_len = int'($urandom_range(1, 5));
      end
      run_xfer(x, $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_master_port.md
Name: serial_master_port

Overview:
- Bus-side serial master interface that drives one slave port over the 1-bit serial system bus.
- Accepts a parallel read/write request from the local master device.
- Serialises the address MSB-first, then the write data MSB-first for writes, on wr_bus.
- For reads, deserialises the returned data from rd_bus. Honours the slave's ready/valid/split handshakes and aborts hung transfers by timeout.

Parameters:
ADDR_WIDTH, 16, address bits serialised per transfer
DATA_WIDTH, 8, data bits per write or read
TIMEOUT, 64, max wait cycles in REQ or WAIT_RD before abort (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
req  in  1  local request strobe, sampled only in IDLE
mode  in  1  1 = write, 0 = read, captured with req
addr  in  ADDR_WIDTH  transfer address, captured with req
wdata  in  DATA_WIDTH  write data, captured with req
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at transfer end
err  out  1  one-cycle pulse coincident with done when the transfer aborted
rdata  out  DATA_WIDTH  read result, valid from the done cycle until the next read's done
wr_bus  out  1  serial address/write-data bit
bus_mode  out  1  captured mode, driven while busy, else 0
master_valid  out  1  master has a bit on wr_bus / request active
master_ready  out  1  master can accept a bit on rd_bus
rd_bus  in  1  serial read-data bit from slave
slave_ready  in  1  slave is accepting wr_bus bits
slave_valid  in  1  slave is driving a valid rd_bus bit
split  in  1  slave has split the read; master waits

Behaviour:
- Reset (rst=1 at an edge): state to IDLE. busy, done, err, wr_bus, bus_mode, master_valid and master_ready all go to 0. rdata=0, bit counter=0, timeout counter=0. Reset mid-transfer abandons it silently, with no done or err.
- States: IDLE, REQ, ADDR, DATA, WAIT_RD, RX, DONE.
- IDLE: when req=1, capture mode/addr/wdata into a shift register {addr,wdata}, clear counters, go to REQ. req outside IDLE is ignored.
- wr_bus always presents the shift register MSB combinationally while master_valid=1, else 0.
- Bit transfer: one bit moves at every edge where master_valid=1 and slave_ready=1. On each transfer the shift register shifts left and the bit counter increments.
- master_valid=1 in REQ, ADDR and DATA only.
- REQ:
  - If slave_ready=1, transfer a bit and go to ADDR.
  - Otherwise increment the timeout counter. On reaching TIMEOUT, go to DONE with err.
- ADDR:
  - If slave_ready=0, go to DONE with err (slave dropped mid-transfer).
  - On the transfer that brings the count to ADDR_WIDTH: go to DATA if mode=1, or to WAIT_RD if mode=0.
- DATA:
  - If slave_ready=0, go to DONE with err.
  - On the transfer that brings the count to ADDR_WIDTH+DATA_WIDTH, go to DONE.
- WAIT_RD:
  - master_valid=0, master_ready=1; bit counter is cleared on entry.
  - If slave_valid=1, shift rd_bus into the LSB of rdata_shift, count 1, go to RX.
  - If split=1, hold and freeze the timeout counter; the split wait is unbounded.
  - Otherwise the timeout counter increments. The timeout counter is cleared on entry to WAIT_RD. At TIMEOUT, go to DONE with err.
- RX:
  - master_ready=1; each edge with slave_valid=1 shifts in one bit.
  - A slave_valid=0 gap stalls without abort.
  - At DATA_WIDTH bits, rdata <= assembled word (MSB first received = rdata[DATA_WIDTH-1]) and go to DONE.
- DONE: done=1 for exactly one cycle; err=1 if entered by abort. Always return to IDLE next cycle.
- Back-to-back: req held high re-launches on the cycle after DONE, i.e. a minimum 1 IDLE cycle between transfers.
- Latency, zero-wait slave: write = 1 (IDLE) + ADDR_WIDTH + DATA_WIDTH transfer cycles + 1 (DONE).
- Counter widths: bit counter $clog2(ADDR_WIDTH+DATA_WIDTH)+1. Timeout counter $clog2(TIMEOUT)+1. No wrap is possible within a transfer.
- rdata is unchanged by write transfers and by aborted reads.

Test Plan:
- Write addr=0x0005, wdata=0xA5, slave_ready tied 1 → wr_bus streams 0000000000000101 then 10100101 over 24 consecutive cycles with master_valid=1; done=1 and err=0 on the next cycle; busy falls the cycle after.
- Read addr=0x0003; slave asserts slave_valid 4 cycles after the address and streams 0x3C → rdata=0x3C at done, err=0, master_ready=1 throughout WAIT_RD/RX.
- Read with split=1 for 200 cycles (TIMEOUT=64), then slave_valid streaming 0xF0 → no timeout; rdata=0xF0, err=0.
- slave_ready held 0 after req → exactly TIMEOUT cycles in REQ, then done=1 and err=1; rdata keeps its previous value.
- slave_ready dropped to 0 after 7 address bits → done and err pulse on the next cycle, then IDLE; a following write of 0x0001/0x11 completes normally.
- rst asserted mid-DATA → next cycle all outputs are 0 and state is IDLE, with no done; req is ignored while busy; a slave_valid gap of 3 cycles in RX stalls without error.
